// File: rtl/stopwatch_core.sv
// stopwatch_core: hh:mm:ss:cc stopwatch timebase + RUN/STOP/CLEAR control, optional lap hold (STOPWATCH_LAP_EN).
// Latency: o_time updates on the edge that consumes a tick; o_running/o_lap_hold one edge after their pulse.
// Backpressure: none; single-cycle button pulses are consumed in the cycle they arrive.
module stopwatch_core #(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int TICK_HZ     = 100,
   parameter int HOUR_MAX    = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_run_stop,
   input  logic        i_clear,
   input  logic        i_mode,
   input  logic        i_lap,
   output logic [31:0] o_time,
   output logic        o_running,
   output logic        o_lap_hold
);

   localparam int DIV   = CLK_FREQ_HZ / TICK_HZ;
   localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
   localparam logic [7:0]       HOUR_LAST = 8'(HOUR_MAX - 1);

   typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_CLEAR} state_t;

   state_t           state_q;
   logic             running_q;
   logic [DIV_W-1:0] div_q, div_d;
   logic [7:0]       hour_q, min_q, sec_q, csec_q;
   logic [7:0]       hour_d, min_d, sec_d, csec_d;
   logic             tick;
   logic [31:0]      live_time;

   // Tick fires on the divider's terminal count, and only while running.
   assign tick      = (state_q == ST_RUN) && (div_q == DIV_LAST);
   assign live_time = {hour_q, min_q, sec_q, csec_q};
   assign o_running = running_q;

   // Control FSM; o_running is registered alongside the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_STOP;
         running_q <= 1'b0;
      end else begin
         case (state_q)
            ST_STOP: begin
               if (i_clear) begin
                  state_q <= ST_CLEAR;
               end else if (i_run_stop) begin
                  state_q   <= ST_RUN;
                  running_q <= 1'b1;
               end
            end
            ST_RUN: begin
               if (i_run_stop) begin
                  state_q   <= ST_STOP;
                  running_q <= 1'b0;
               end
            end
            ST_CLEAR: begin
               state_q <= ST_STOP;
            end
            default: begin
               state_q   <= ST_STOP;
               running_q <= 1'b0;
            end
         endcase
      end
   end

   // Divider advances only in RUN and keeps its phase across STOP; CLEAR rewinds it.
   always_comb begin
      div_d = div_q;
      if (state_q == ST_CLEAR) begin
         div_d = '0;
      end else if (state_q == ST_RUN) begin
         div_d = tick ? '0 : div_q + 1'b1;
      end
   end

   // Carry/borrow chain across csec/sec/min/hour; each field is compared to its limit before stepping.
   always_comb begin
      csec_d = csec_q;
      sec_d  = sec_q;
      min_d  = min_q;
      hour_d = hour_q;
      if (state_q == ST_CLEAR) begin
         csec_d = '0;
         sec_d  = '0;
         min_d  = '0;
         hour_d = '0;
      end else if (tick && !i_mode) begin
         if (csec_q == 8'd99) begin
            csec_d = '0;
            if (sec_q == 8'd59) begin
               sec_d = '0;
               if (min_q == 8'd59) begin
                  min_d  = '0;
                  hour_d = (hour_q == HOUR_LAST) ? 8'd0 : hour_q + 8'd1;
               end else begin
                  min_d = min_q + 8'd1;
               end
            end else begin
               sec_d = sec_q + 8'd1;
            end
         end else begin
            csec_d = csec_q + 8'd1;
         end
      end else if (tick && i_mode) begin
         if (csec_q == 8'd0) begin
            csec_d = 8'd99;
            if (sec_q == 8'd0) begin
               sec_d = 8'd59;
               if (min_q == 8'd0) begin
                  min_d  = 8'd59;
                  hour_d = (hour_q == 8'd0) ? HOUR_LAST : hour_q - 8'd1;
               end else begin
                  min_d = min_q - 8'd1;
               end
            end else begin
               sec_d = sec_q - 8'd1;
            end
         end else begin
            csec_d = csec_q - 8'd1;
         end
      end
   end

   // Divider and time-field registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q  <= '0;
         csec_q <= '0;
         sec_q  <= '0;
         min_q  <= '0;
         hour_q <= '0;
      end else begin
         div_q  <= div_d;
         csec_q <= csec_d;
         sec_q  <= sec_d;
         min_q  <= min_d;
         hour_q <= hour_d;
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic        hold_q;
   logic [31:0] snap_q;

   // Lap hold: RUN pulses toggle and snapshot the pre-edge time; STOP pulses or entering CLEAR release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q <= 1'b0;
         snap_q <= '0;
      end else if (state_q == ST_STOP && i_clear) begin
         hold_q <= 1'b0;
      end else if (state_q == ST_RUN && i_lap) begin
         hold_q <= ~hold_q;
         if (!hold_q) begin
            snap_q <= live_time;
         end
      end else if (state_q == ST_STOP && i_lap) begin
         hold_q <= 1'b0;
      end
   end

   assign o_time     = hold_q ? snap_q : live_time;
   assign o_lap_hold = hold_q;
`else
   logic unused_lap;

   assign unused_lap = i_lap;
   assign o_time     = live_time;
   assign o_lap_hold = 1'b0;
`endif

endmodule
